// File: rtl/booth_r4_pkg.sv
// Shared constants and strobe decoding for the radix-4 Booth multiplier datapath.
// The control unit issues one-hot strobes; decode_op resolves overlaps by fixed priority.
package booth_r4_pkg;

  localparam int N     = 8;
  localparam int CNT_W = 2;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD_M,
    OP_LOAD_Q,
    OP_ADD,
    OP_SHIFT,
    OP_OUT_HI,
    OP_OUT_LO
  } op_e;

  // c3/c4 only qualify an add, so they take no part in selecting the operation.
  function automatic op_e decode_op(input logic c0, input logic c1, input logic c2,
                                    input logic c5, input logic c6, input logic c7);
    op_e op;
    if (c0)      op = OP_LOAD_M;
    else if (c1) op = OP_LOAD_Q;
    else if (c2) op = OP_ADD;
    else if (c5) op = OP_SHIFT;
    else if (c6) op = OP_OUT_HI;
    else if (c7) op = OP_OUT_LO;
    else         op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/booth_r4_addsub.sv
// Booth partial-product adder: A +/- (M or 2M), evaluated at N+2 bits.
// Results wrap; the two headroom bits make every legal Booth step representable.
module booth_r4_addsub
  import booth_r4_pkg::*;
(
  input  logic signed [N+1:0] a,
  input  logic        [N-1:0] m,
  input  logic                sel2m,
  input  logic                sub,
  output logic signed [N+1:0] sum
);

  logic signed [N+1:0] m_ext;
  logic signed [N+1:0] operand;

  assign m_ext   = {{2{m[N-1]}}, m};
  assign operand = sel2m ? (m_ext <<< 1) : m_ext;
  assign sum     = sub ? (a - operand) : (a + operand);

endmodule

// File: rtl/booth_r4_datapath.sv
// Radix-4 Booth multiplier datapath: executes control-unit strobes c0..c7 on {A,Q,Q_1},
// reports the next recoding triplet and last-iteration flag, and emits the product as two words.
module booth_r4_datapath
  import booth_r4_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         c0,
  input  logic         c1,
  input  logic         c2,
  input  logic         c3,
  input  logic         c4,
  input  logic         c5,
  input  logic         c6,
  input  logic         c7,
  input  logic [N-1:0] inbus,
  output logic [2:0]   q_lsb,
  output logic         count3,
  output logic [N-1:0] outbus,
  output logic         out_valid,
  output logic         out_hi
);

  logic signed [N+1:0] a_q, a_d;
  logic        [N-1:0] m_q, m_d;
  logic        [N-1:0] q_q, q_d;
  logic                q1_q, q1_d;
  logic    [CNT_W-1:0] cnt_q, cnt_d;
  logic        [N-1:0] outbus_q, outbus_d;
  logic                out_valid_q, out_valid_d;
  logic                out_hi_q, out_hi_d;

  logic signed [N+1:0] sum;
  logic      [2*N-1:0] prod;
  op_e                 op;

  assign op = decode_op(c0, c1, c2, c5, c6, c7);

  booth_r4_addsub u_addsub (
    .a     (a_q),
    .m     (m_q),
    .sel2m (c3),
    .sub   (c4),
    .sum   (sum)
  );

  // The final digit is added without a shift, so the low two Q bits are still unconsumed multiplier.
  assign prod = {a_q, q_q[N-1:2]};

  always_comb begin
    a_d         = a_q;
    m_d         = m_q;
    q_d         = q_q;
    q1_d        = q1_q;
    cnt_d       = cnt_q;
    outbus_d    = outbus_q;
    out_valid_d = 1'b0;
    out_hi_d    = out_hi_q;
    case (op)
      OP_LOAD_M: begin
        m_d   = inbus;
        a_d   = '0;
        cnt_d = '0;
      end
      OP_LOAD_Q: begin
        q_d  = inbus;
        q1_d = 1'b0;
      end
      OP_ADD: a_d = sum;
      OP_SHIFT: begin
        a_d   = {{2{a_q[N+1]}}, a_q[N+1:2]};
        q_d   = {a_q[1:0], q_q[N-1:2]};
        q1_d  = q_q[1];
        cnt_d = cnt_q + CNT_W'(1);
      end
      OP_OUT_HI: begin
        outbus_d    = prod[2*N-1:N];
        out_valid_d = 1'b1;
        out_hi_d    = HI;
      end
      OP_OUT_LO: begin
        outbus_d    = prod[N-1:0];
        out_valid_d = 1'b1;
        out_hi_d    = LO;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      m_q         <= '0;
      q_q         <= '0;
      q1_q        <= 1'b0;
      cnt_q       <= '0;
      outbus_q    <= '0;
      out_valid_q <= 1'b0;
      out_hi_q    <= 1'b0;
    end else begin
      a_q         <= a_d;
      m_q         <= m_d;
      q_q         <= q_d;
      q1_q        <= q1_d;
      cnt_q       <= cnt_d;
      outbus_q    <= outbus_d;
      out_valid_q <= out_valid_d;
      out_hi_q    <= out_hi_d;
    end
  end

  assign q_lsb     = {q_q[1], q_q[0], q1_q};
  assign count3    = (cnt_q == CNT_W'(N/2 - 1));
  assign outbus    = outbus_q;
  assign out_valid = out_valid_q;
  assign out_hi    = out_hi_q;

endmodule

// File: tb/tb_booth_r4_datapath.sv
// Bench for booth_r4_datapath: plays the control unit from the multiplier's Booth digits and
// compares every cycle against a signed-product model; directed cases pin literal results.
module tb_booth_r4_datapath;

  localparam logic [7:0] S_C0 = 8'h01;
  localparam logic [7:0] S_C1 = 8'h02;
  localparam logic [7:0] S_C2 = 8'h04;
  localparam logic [7:0] S_C3 = 8'h08;
  localparam logic [7:0] S_C4 = 8'h10;
  localparam logic [7:0] S_C5 = 8'h20;
  localparam logic [7:0] S_C6 = 8'h40;
  localparam logic [7:0] S_C7 = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
  logic       c4 = 1'b0, c5 = 1'b0, c6 = 1'b0, c7 = 1'b0;
  logic [7:0] inbus = 8'h00;
  logic [2:0] q_lsb;
  logic       count3;
  logic [7:0] outbus;
  logic       out_valid;
  logic       out_hi;

  always #5 clk = ~clk;

  booth_r4_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .c5        (c5),
    .c6        (c6),
    .c7        (c7),
    .inbus     (inbus),
    .q_lsb     (q_lsb),
    .count3    (count3),
    .outbus    (outbus),
    .out_valid (out_valid),
    .out_hi    (out_hi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the outputs must show after the most recent clock edge.
  logic        chk_en = 1'b0;
  logic [2:0]  exp_q_lsb = 3'b000;
  logic        exp_count3 = 1'b0;
  logic [7:0]  exp_out = 8'h00;
  logic        exp_valid = 1'b0;
  logic        exp_hi = 1'b0;
  logic [15:0] exp_prod = 16'h0000;
  logic [7:0]  mult = 8'h00;
  int          model_cnt = 0;
  int          shifts = 0;

  logic [7:0]  cap_hi, cap_lo;
  logic [2:0]  q_lsb_c1;
  logic        cnt3_before, cnt3_after;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Booth triplet {b[2j+1], b[2j], b[2j-1]} with b[-1] = 0.
  function automatic logic [2:0] recode_bits(input logic [7:0] b, input int j);
    logic [8:0] ext;
    ext = {b, 1'b0};
    return {ext[2*j+2], ext[2*j+1], ext[2*j]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("q_lsb", {29'd0, q_lsb}, {29'd0, exp_q_lsb});
      check("count3", {31'd0, count3}, {31'd0, exp_count3});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("outbus", {24'd0, outbus}, {24'd0, exp_out});
      if (exp_valid) check("out_hi", {31'd0, out_hi}, {31'd0, exp_hi});
      if (out_valid && out_hi)  cap_hi = outbus;
      if (out_valid && !out_hi) cap_lo = outbus;
    end
  end

  // Drive one cycle of strobes, then advance the model by whichever strobe wins.
  task automatic step(input logic [7:0] s, input logic [7:0] bus);
    {c7, c6, c5, c4, c3, c2, c1, c0} = s;
    inbus = bus;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (s[0]) begin
      model_cnt = 0;
    end else if (s[1]) begin
      mult = bus;
      shifts = 0;
      exp_q_lsb = recode_bits(bus, 0);
    end else if (s[2]) begin
      // A changes only; nothing visible until the product is read.
    end else if (s[5]) begin
      model_cnt = (model_cnt + 1) % 4;
      shifts++;
      if (shifts <= 3) exp_q_lsb = recode_bits(mult, shifts);
    end else if (s[6]) begin
      exp_valid = 1'b1;
      exp_hi = 1'b1;
      exp_out = exp_prod[15:8];
    end else if (s[7]) begin
      exp_valid = 1'b1;
      exp_hi = 1'b0;
      exp_out = exp_prod[7:0];
    end
    exp_count3 = (model_cnt == 3);
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) step(8'h00, 8'($urandom));
  endtask

  task automatic apply_reset();
    {c7, c6, c5, c4, c3, c2, c1, c0} = 8'h00;
    reset = 1'b0;
    exp_q_lsb = 3'b000;
    exp_count3 = 1'b0;
    exp_out = 8'h00;
    exp_valid = 1'b0;
    exp_prod = 16'h0000;
    model_cnt = 0;
    shifts = 0;
    mult = 8'h00;
    #1;
    check("rst outbus", {24'd0, outbus}, 32'h0);
    check("rst q_lsb", {29'd0, q_lsb}, 32'h0);
    check("rst out_valid", {31'd0, out_valid}, 32'h0);
    check("rst out_hi", {31'd0, out_hi}, 32'h0);
    check("rst count3", {31'd0, count3}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic multiply(input logic [7:0] a, input logic [7:0] b,
                          input bit conflict, input bit idles);
    logic signed [15:0] sa, sb;
    logic [2:0] bits;
    logic [7:0] s;
    int d, b0, b1, b2;
    cap_hi = 8'hxx;
    cap_lo = 8'hxx;
    sa = $signed(a);
    sb = $signed(b);
    exp_prod = sa * sb;
    step(S_C0, a);
    if (idles) gap();
    step(S_C1, b);
    q_lsb_c1 = q_lsb;
    for (int i = 0; i < 4; i++) begin
      bits = recode_bits(b, i);
      b0 = bits[0];
      b1 = bits[1];
      b2 = bits[2];
      d = b1 + b0 - 2 * b2;
      if (conflict && i == 0) step(S_C3 | S_C4, 8'($urandom));
      if (d != 0) begin
        s = S_C2 | ((d == 2 || d == -2) ? S_C3 : 8'h00) | ((d < 0) ? S_C4 : 8'h00);
        if (conflict && i == 0) s = s | S_C5;
        step(s, 8'($urandom));
      end
      if (idles) gap();
      if (i < 3) begin
        if (i == 2) cnt3_before = count3;
        step((conflict && i == 1) ? (S_C5 | S_C6) : S_C5, 8'($urandom));
        if (i == 2) cnt3_after = count3;
      end
    end
    step(S_C6, 8'($urandom));
    if (idles) gap();
    step(S_C7, 8'($urandom));
    step(8'h00, 8'($urandom));
  endtask

  task automatic expect_words(input string name, input logic [7:0] hi, input logic [7:0] lo);
    check({name, " hi"}, {24'd0, cap_hi}, {24'd0, hi});
    check({name, " lo"}, {24'd0, cap_lo}, {24'd0, lo});
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corners [5];
    corners = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    apply_reset();

    multiply(8'h07, 8'h03, 1'b0, 1'b0);
    expect_words("7x3", 8'h00, 8'h15);
    multiply(8'h05, 8'hFD, 1'b0, 1'b1);
    expect_words("5x-3", 8'hFF, 8'hF1);
    multiply(8'h80, 8'h80, 1'b0, 1'b0);
    expect_words("-128x-128", 8'h40, 8'h00);
    multiply(8'h7F, 8'h80, 1'b0, 1'b0);
    expect_words("127x-128", 8'hC0, 8'h80);

    multiply(8'h13, 8'h6B, 1'b0, 1'b0);
    expect_words("0x13x0x6B", 8'h07, 8'hF1);
    check("q_lsb after c1", {29'd0, q_lsb_c1}, {29'd0, 3'b110});
    check("count3 before 3rd c5", {31'd0, cnt3_before}, 32'h0);
    check("count3 after 3rd c5", {31'd0, cnt3_after}, 32'h1);

    // Abort a multiply after its second shift.
    step(S_C0, 8'h09);
    step(S_C1, 8'h6B);
    step(S_C2 | S_C4, 8'h00);
    step(S_C5, 8'h00);
    step(S_C2 | S_C4, 8'h00);
    step(S_C5, 8'h00);
    apply_reset();
    cap_hi = 8'hxx;
    cap_lo = 8'hxx;
    step(S_C6, 8'h00);
    step(S_C7, 8'h00);
    step(8'h00, 8'h00);
    expect_words("post-reset product", 8'h00, 8'h00);
    multiply(8'h02, 8'h02, 1'b0, 1'b0);
    expect_words("2x2", 8'h00, 8'h04);

    multiply(8'h13, 8'h6B, 1'b1, 1'b0);
    expect_words("conflict 0x13x0x6B", 8'h07, 8'hF1);

    for (int k = 0; k < 40; k++) begin
      ra = pick_operand();
      rb = pick_operand();
      multiply(ra, rb, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
